// File: rtl/ccip_mmio_csr_pkg.sv
// rtl/ccip_mmio_csr_pkg.sv - register map, length codes, index decode and write-merge helper for the AFU MMIO CSR block
package ccip_mmio_csr_pkg;

    localparam logic [17:0] CSR_DFH_OFF      = 18'h00000;
    localparam logic [17:0] CSR_AFU_ID_L_OFF = 18'h00008;
    localparam logic [17:0] CSR_AFU_ID_H_OFF = 18'h00010;
    localparam logic [17:0] CSR_NEXT_AFU_OFF = 18'h00018;
    localparam logic [17:0] CSR_RSVD_OFF     = 18'h00020;
    localparam logic [17:0] CSR_SCRATCH_OFF  = 18'h00028;
    localparam logic [17:0] CSR_CTL_OFF      = 18'h00030;
    localparam logic [17:0] CSR_STATUS_OFF   = 18'h00038;
    localparam logic [17:0] CSR_CNT_OFF      = 18'h00040;

    localparam logic [1:0] CCIP_MMIO_LEN_4B = 2'd0;
    localparam logic [1:0] CCIP_MMIO_LEN_8B = 2'd1;

    typedef enum logic [3:0] {
        CSR_IDX_DFH,
        CSR_IDX_AFU_ID_L,
        CSR_IDX_AFU_ID_H,
        CSR_IDX_NEXT_AFU,
        CSR_IDX_RSVD,
        CSR_IDX_SCRATCH,
        CSR_IDX_CTL,
        CSR_IDX_STATUS,
        CSR_IDX_CNT,
        CSR_IDX_NONE
    } t_csr_idx;

    // addr is in 4-byte units; bit 0 only selects a half, so decode at 8-byte granularity
    function automatic t_csr_idx csr_addr_to_idx(input logic [15:0] addr);
        logic [17:0] byte_off;
        t_csr_idx    idx;
        byte_off = {addr[15:1], 3'b000};
        case (byte_off)
            CSR_DFH_OFF:      idx = CSR_IDX_DFH;
            CSR_AFU_ID_L_OFF: idx = CSR_IDX_AFU_ID_L;
            CSR_AFU_ID_H_OFF: idx = CSR_IDX_AFU_ID_H;
            CSR_NEXT_AFU_OFF: idx = CSR_IDX_NEXT_AFU;
            CSR_RSVD_OFF:     idx = CSR_IDX_RSVD;
            CSR_SCRATCH_OFF:  idx = CSR_IDX_SCRATCH;
            CSR_CTL_OFF:      idx = CSR_IDX_CTL;
            CSR_STATUS_OFF:   idx = CSR_IDX_STATUS;
            CSR_CNT_OFF:      idx = CSR_IDX_CNT;
            default:          idx = CSR_IDX_NONE;
        endcase
        return idx;
    endfunction

    // 4B writes carry their payload in data[31:0]; addr[0] picks which half it lands in
    function automatic logic [63:0] csr_merge(input logic [63:0] cur, input logic [63:0] wdata,
                                              input logic is_8b, input logic hi);
        logic [63:0] res;
        if (is_8b) begin
            res = wdata;
        end else if (hi) begin
            res = {wdata[31:0], cur[31:0]};
        end else begin
            res = {cur[63:32], wdata[31:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ccip_mmio_csr.sv
// rtl/ccip_mmio_csr.sv - CCI-P AFU MMIO register block: DFH, AFU ID, scratch, ctl, status and cycle counter
// Two-stage pipeline: requests are captured, then read data is muxed and writes commit on the same edge.
module ccip_mmio_csr
    import ccip_mmio_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
    parameter logic [63:0] CTL_RESET = 64'h0
) (
    input  logic        Clk_400,
    input  logic        SoftReset,
    input  logic        mmio_rd_valid,
    input  logic        mmio_wr_valid,
    input  logic [15:0] mmio_addr,
    input  logic [1:0]  mmio_len,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic [63:0] csr_ctl,
    output logic        csr_ctl_wr,
    input  logic [63:0] csr_status
);

    t_csr_idx    addr_idx_d;
    logic        wr_ok_d;

    logic        rd_vld_q;
    logic [8:0]  rd_tid_q;
    t_csr_idx    rd_idx_q;
    logic        wr_vld_q;
    t_csr_idx    wr_idx_q;
    logic        wr_8b_q;
    logic        wr_hi_q;
    logic [63:0] wr_data_q;

    logic        rsp_valid_q;
    logic [8:0]  rsp_tid_q;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [63:0] scratch_q, scratch_d;
    logic [63:0] ctl_q, ctl_d;
    logic        ctl_wr_q, ctl_wr_d;
    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        addr_idx_d = csr_addr_to_idx(mmio_addr);
        // reserved length codes never reach the commit stage
        wr_ok_d    = mmio_wr_valid &&
                     ((mmio_len == CCIP_MMIO_LEN_4B) || (mmio_len == CCIP_MMIO_LEN_8B));
    end

    // Read mux sees register state before this edge's write commit.
    always_comb begin
        rsp_data_d = rsp_data_q;
        if (rd_vld_q) begin
            case (rd_idx_q)
                CSR_IDX_DFH:      rsp_data_d = DFH_VALUE;
                CSR_IDX_AFU_ID_L: rsp_data_d = AFU_ID_L;
                CSR_IDX_AFU_ID_H: rsp_data_d = AFU_ID_H;
                CSR_IDX_SCRATCH:  rsp_data_d = scratch_q;
                CSR_IDX_CTL:      rsp_data_d = ctl_q;
                CSR_IDX_STATUS:   rsp_data_d = csr_status;
                CSR_IDX_CNT:      rsp_data_d = cnt_q;
                default:          rsp_data_d = 64'h0;
            endcase
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        ctl_d     = ctl_q;
        ctl_wr_d  = 1'b0;
        cnt_d     = cnt_q + 64'd1;
        if (wr_vld_q) begin
            case (wr_idx_q)
                CSR_IDX_SCRATCH: scratch_d = csr_merge(scratch_q, wr_data_q, wr_8b_q, wr_hi_q);
                CSR_IDX_CTL: begin
                    ctl_d    = csr_merge(ctl_q, wr_data_q, wr_8b_q, wr_hi_q);
                    ctl_wr_d = 1'b1;
                end
                CSR_IDX_CNT:     cnt_d = 64'h0;
                default:         ;
            endcase
        end
    end

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            rd_vld_q    <= 1'b0;
            rd_tid_q    <= 9'h0;
            rd_idx_q    <= CSR_IDX_NONE;
            wr_vld_q    <= 1'b0;
            wr_idx_q    <= CSR_IDX_NONE;
            wr_8b_q     <= 1'b0;
            wr_hi_q     <= 1'b0;
            wr_data_q   <= 64'h0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= 9'h0;
            rsp_data_q  <= 64'h0;
            scratch_q   <= 64'h0;
            ctl_q       <= CTL_RESET;
            ctl_wr_q    <= 1'b0;
            cnt_q       <= 64'h0;
        end else begin
            rd_vld_q    <= mmio_rd_valid;
            rd_tid_q    <= mmio_tid;
            rd_idx_q    <= addr_idx_d;
            wr_vld_q    <= wr_ok_d;
            wr_idx_q    <= addr_idx_d;
            wr_8b_q     <= (mmio_len == CCIP_MMIO_LEN_8B);
            wr_hi_q     <= mmio_addr[0];
            wr_data_q   <= mmio_wdata;
            rsp_valid_q <= rd_vld_q;
            rsp_tid_q   <= rd_tid_q;
            rsp_data_q  <= rsp_data_d;
            scratch_q   <= scratch_d;
            ctl_q       <= ctl_d;
            ctl_wr_q    <= ctl_wr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_tid    = rsp_tid_q;
    assign rsp_data   = rsp_data_q;
    assign csr_ctl    = ctl_q;
    assign csr_ctl_wr = ctl_wr_q;

endmodule

// File: doc/ccip_mmio_csr.md
Name: ccip_mmio_csr

Overview:
- AFU-side MMIO register block fed by the CCI-P async shim's AFU-clock Rx port (c0 MMIO requests); drives the c2 Tx MMIO read-response channel back into the shim.
- Hosts the mandatory device feature header (DFH) and the 128-bit AFU ID.
- Also hosts a scratch register, a control register exported to user logic, a status register imported from user logic, and a free-running cycle counter.
- Pipelined, no backpressure, fixed read latency.

Parameters:
- AFU_ID_L, 64'h0, low 64 bits of the AFU UUID.
- AFU_ID_H, 64'h0, high 64 bits of the AFU UUID.
- DFH_VALUE, 64'h1000_0000_0000_0000, value returned at offset 0x000 (type=AFU, EOL=0, next=0).
- CTL_RESET, 64'h0, reset value of the control register.

Ports:
- Clk_400  in  1  AFU clock, as delivered to the user AFU.
- SoftReset  in  1  asynchronous, active-high reset.
- mmio_rd_valid  in  1  c0 Rx mmioRdValid.
- mmio_wr_valid  in  1  c0 Rx mmioWrValid.
- mmio_addr  in  16  c0 MMIO header address, in 4-byte units.
- mmio_len  in  2  c0 MMIO header length; 0=4B, 1=8B, others reserved.
- mmio_tid  in  9  c0 MMIO header tid.
- mmio_wdata  in  64  c0 Rx data[63:0].
- rsp_valid  out  1  c2 Tx mmioRdValid.
- rsp_tid  out  9  c2 Tx header tid.
- rsp_data  out  64  c2 Tx data.
- csr_ctl  out  64  control register, to user logic.
- csr_ctl_wr  out  1  one-cycle pulse whenever csr_ctl is written.
- csr_status  in  64  user status, read-only.

Behaviour:
- Register map (byte offset = mmio_addr<<2; decode uses addr[15:1], i.e. 8-byte granularity):
  - 0x000 DFH (RO)
  - 0x008 AFU_ID_L (RO)
  - 0x010 AFU_ID_H (RO)
  - 0x018 next-AFU (RO, 0)
  - 0x020 reserved (RO, 0)
  - 0x028 scratch (RW)
  - 0x030 ctl (RW)
  - 0x038 status (RO, mirrors csr_status)
  - 0x040 cycle counter (RO; any write clears it to 0)
  - Everything else: reads return 0, writes are ignored.
- Reset (async assert; release synchronous to Clk_400):
  - rsp_valid=0, rsp_tid=0, rsp_data=0.
  - scratch=0, ctl=CTL_RESET, csr_ctl_wr=0, counter=0.
- Read pipeline: fixed 2-cycle latency, no stall path.
  - Cycle T: request sampled into stage-1 registers (valid, tid, decoded index).
  - Cycle T+1: data muxed and registered.
  - rsp_valid high for exactly one cycle at T+2, with the captured tid.
  - Back-to-back reads on consecutive cycles produce back-to-back responses in order.
- Read data width:
  - 8B read: full 64-bit register.
  - 4B read: the 64-bit register is returned regardless of addr[0]. Host software selects the half.
- Write rules:
  - 8B write: full register updated at T+1.
  - 4B write: addr[0]=0 updates bits[31:0], addr[0]=1 updates bits[63:32]; the other half is held.
  - Reserved length codes (2, 3): treated as no-op for writes; reads still respond with 64-bit data.
- csr_ctl_wr pulses in the same cycle csr_ctl takes its new value, including for 4B partial writes.
- Simultaneous rd_valid and wr_valid (not produced by the platform, but defined here):
  - Both are processed.
  - The read returns the pre-write value, because read data is sampled at T+1 from the register state before that cycle's write commit.
- Read following a write on the next cycle returns the new value.
- Cycle counter:
  - 64-bit, increments every cycle, wraps 2^64-1 to 0 silently.
  - A write clears it at T+1; it resumes incrementing at T+2.
  - A read returns the value registered at T+1.
- csr_status is sampled at T+1 of the read; no synchronisation (same clock domain).
- Reset mid-operation: in-flight reads are dropped, and no response is issued for them after reset release.

Decomposition:
- Shared package ccip_mmio_csr_pkg:
  - Byte-offset localparams for every register.
  - Length encodings CCIP_MMIO_LEN_4B/8B.
  - A t_csr_idx enum for decoded register index.
  - A function converting a 4-byte-unit address to the index.
- No sub-module required; a single module is natural. The counter may be a small inline always block.

Test Plan:
- Read DFH, tid=0x1A5, after reset -> rsp_valid exactly 2 cycles later, rsp_tid=0x1A5, rsp_data=DFH_VALUE; read 0x008/0x010 -> AFU_ID_L/H.
- 8B write 0xDEADBEEF_CAFEF00D to scratch (addr=0x000A), then read -> 0xDEADBEEF_CAFEF00D; 4B write 0x12345678 at addr=0x000B, read -> 0x12345678_CAFEF00D.
- 8B write 0x5 to ctl (addr=0x000C) -> csr_ctl=0x5 and csr_ctl_wr=1 for one cycle, 1 cycle after the request; unmapped write at addr=0x0100 -> no pulse, no change; read at 0x0100 -> 0.
- 4 back-to-back reads, tids 1..4, to status with csr_status=0xABCD -> four consecutive rsp_valid cycles, tids 1,2,3,4 in order, data 0xABCD.
- Counter: write any value to 0x040 then read 8 cycles later -> value in small fixed expected range (compute exactly from latency); force counter to 2^64-1 -> next read reflects wrap to low value.
- Assert SoftReset while two reads are in flight -> no rsp_valid after release; scratch=0, ctl=CTL_RESET; a subsequent read responds normally.
